// File: rtl/board_pkg.sv
// Shared types and constants for the board memory arbiter and its win evaluator.
package board_pkg;

    localparam int         CELLS     = 9;
    localparam logic [3:0] NO_ADDR   = 4'hF;
    localparam int         NUM_LINES = 8;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_X     = 2'b10,
        CELL_O     = 2'b11
    } cellStateType;

    localparam logic [1:0] WIN_P1 = 2'b11;
    localparam logic [1:0] WIN_P2 = 2'b10;
    localparam logic [1:0] TIE    = 2'b01;
    localparam logic [1:0] NONE   = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WRITE,
        ST_SCAN,
        ST_EVAL
    } arbStateType;

    // Rows, then columns, then the two diagonals.
    localparam logic [3:0] LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

endpackage

// File: rtl/win_eval.sv
// Combinational win/tie detector over the 9-cell shadow board.
module win_eval
    import board_pkg::*;
(
    input  logic [CELLS-1:0][1:0] board,
    output logic [1:0]            winner
);

    logic       found;
    logic       anyEmpty;
    logic [1:0] cellA;
    logic [1:0] cellB;
    logic [1:0] cellC;

    // First complete line in table order wins; a full board without a line is a tie.
    always_comb begin
        winner   = NONE;
        found    = 1'b0;
        anyEmpty = 1'b0;
        cellA    = CELL_EMPTY;
        cellB    = CELL_EMPTY;
        cellC    = CELL_EMPTY;
        for (int i = 0; i < CELLS; i++) begin
            if (board[i] == CELL_EMPTY) begin
                anyEmpty = 1'b1;
            end
        end
        for (int l = 0; l < NUM_LINES; l++) begin
            cellA = board[LINES[l][0]];
            cellB = board[LINES[l][1]];
            cellC = board[LINES[l][2]];
            if (!found && cellA != CELL_EMPTY && cellA == cellB && cellA == cellC) begin
                found  = 1'b1;
                winner = (cellA == CELL_O) ? WIN_P1 :
                         (cellA == CELL_X) ? WIN_P2 : cellA;
            end
        end
        if (!found && !anyEmpty) begin
            winner = TIE;
        end
    end

endmodule

// File: rtl/board_access_arbiter.sv
// Owns the board memory port: clears, move writes, post-move win scans and idle-time reads.
module board_access_arbiter
    import board_pkg::*;
#(
    parameter int CELLS  = 9,
    parameter int ADDR_W = 4
) (
    input  logic              ph1,
    input  logic              reset,
    input  logic              clearReq,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [1:0]        wrState,
    output logic              wrDrop,
    input  logic              rdReq,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic              rdGnt,
    output logic              rdValid,
    output logic [1:0]        rdData,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memWe,
    output logic [1:0]        memWdata,
    input  logic [1:0]        memRdata,
    output logic              gameIsDone,
    output logic [1:0]        winner,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(CELLS - 1);
    localparam logic [3:0]        CLEAR_LAST = 4'(CELLS - 1);
    localparam logic [3:0]        SCAN_LAST  = 4'(CELLS);

    arbStateType           state;
    arbStateType           stateNext;
    logic [3:0]            count;
    logic [3:0]            scanIdx;
    logic                  pendValid;
    logic [ADDR_W-1:0]     pendAddr;
    logic [1:0]            pendState;
    logic [ADDR_W-1:0]     moveAddr;
    logic [1:0]            moveState;
    logic                  clearPend;
    logic                  capture;
    logic                  consume;
    logic                  enterClear;
    logic                  abortScan;
    logic                  rdOutOfRange;
    logic [CELLS-1:0][1:0] shadow;
    logic [1:0]            evalWinner;

    assign capture = (wrAddr <= LAST_CELL);
    assign scanIdx = count - 4'd1;
    assign busy    = (state != ST_IDLE);

    // Next-state logic; in IDLE a pending clear beats a pending move, which beats a read.
    always_comb begin
        stateNext  = state;
        rdGnt      = 1'b0;
        consume    = 1'b0;
        enterClear = 1'b0;
        abortScan  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clearPend) begin
                    stateNext  = ST_CLEAR;
                    enterClear = 1'b1;
                end else if (pendValid) begin
                    stateNext = ST_WRITE;
                    consume   = 1'b1;
                end else if (rdReq && !reset) begin
                    rdGnt = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (count == CLEAR_LAST) begin
                    stateNext = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (clearPend || clearReq) begin
                    stateNext  = ST_CLEAR;
                    enterClear = 1'b1;
                end else begin
                    stateNext = ST_SCAN;
                end
            end
            ST_SCAN, ST_EVAL: begin
                if (clearReq) begin
                    stateNext  = ST_CLEAR;
                    enterClear = 1'b1;
                    abortScan  = 1'b1;
                end else if (state == ST_EVAL) begin
                    stateNext = ST_IDLE;
                end else if (count == SCAN_LAST) begin
                    stateNext = ST_EVAL;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= stateNext;
            if (stateNext != state) begin
                count <= '0;
            end else if (state == ST_CLEAR || state == ST_SCAN) begin
                count <= count + 4'd1;
            end
        end
    end

    // One-deep move buffer; a move landing on an occupied buffer is dropped unless it is being drained.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            pendValid <= 1'b0;
            pendAddr  <= '0;
            pendState <= '0;
            moveAddr  <= '0;
            moveState <= '0;
            wrDrop    <= 1'b0;
            clearPend <= 1'b0;
        end else begin
            wrDrop <= capture && pendValid && !consume && !abortScan;
            if (abortScan) begin
                pendValid <= 1'b0;
            end else if (capture && (!pendValid || consume)) begin
                pendValid <= 1'b1;
                pendAddr  <= wrAddr;
                pendState <= wrState;
            end else if (consume) begin
                pendValid <= 1'b0;
            end
            if (consume) begin
                moveAddr  <= pendAddr;
                moveState <= pendState;
            end
            if (enterClear) begin
                clearPend <= 1'b0;
            end else if (clearReq) begin
                clearPend <= 1'b1;
            end
        end
    end

    // Scan read data trails its address by one cycle, so cycle k fills shadow cell k-1.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            shadow     <= '0;
            winner     <= NONE;
            gameIsDone <= 1'b0;
        end else begin
            if (state == ST_SCAN && count != 4'd0) begin
                shadow[scanIdx] <= memRdata;
            end
            if (enterClear) begin
                winner     <= NONE;
                gameIsDone <= 1'b0;
            end else if (state == ST_EVAL) begin
                winner     <= evalWinner;
                gameIsDone <= (evalWinner != NONE);
            end
        end
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            rdValid      <= 1'b0;
            rdOutOfRange <= 1'b0;
        end else begin
            rdValid      <= rdGnt;
            rdOutOfRange <= rdGnt && (rdAddr > LAST_CELL);
        end
    end

    assign rdData = (rdValid && !rdOutOfRange) ? memRdata : 2'b00;

    // Memory port decode from state and counter; only a granted read drives the address combinationally.
    always_comb begin
        memAddr  = NO_ADDR;
        memWe    = 1'b0;
        memWdata = 2'b00;
        case (state)
            ST_IDLE: begin
                if (rdGnt) begin
                    memAddr = rdAddr;
                end
            end
            ST_CLEAR: begin
                memAddr = ADDR_W'(count);
                memWe   = 1'b1;
            end
            ST_WRITE: begin
                memAddr  = moveAddr;
                memWe    = 1'b1;
                memWdata = moveState;
            end
            ST_SCAN: begin
                if (count <= CLEAR_LAST) begin
                    memAddr = ADDR_W'(count);
                end
            end
            default: begin
                memAddr = NO_ADDR;
            end
        endcase
    end

    win_eval u_winEval (
        .board  (shadow),
        .winner (evalWinner)
    );

endmodule
